// File: rtl/rr_mux_nbit_x4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared constants and round-robin pick helper for the 4-to-1 merger
// Revision: 1.0
// ============================================================================
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Walk downward so the candidate closest to ptr is the last one written.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req,
                                    input logic [SEL_W-1:0]  ptr);
    pick_t            r_res;
    logic [SEL_W-1:0] w_i;
    r_res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_i = ptr + SEL_W'(k);
      if (req[w_i]) begin
        r_res.found = 1'b1;
        r_res.idx   = w_i;
      end
    end
    return r_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_nbit_x4_if.sv
`default_nettype none
// ============================================================================
// Module  : rr_mux_nbit_x4_if
// Brief   : Four input streams plus the merged output stream and counter
// Revision: 1.0
// ============================================================================
interface rr_mux_nbit_x4_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 16
);
  import mux_pkg::*;

  logic [BUS_WIDTH-1:0] a;
  logic [BUS_WIDTH-1:0] b;
  logic [BUS_WIDTH-1:0] c;
  logic [BUS_WIDTH-1:0] d;
  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH-1:0]    in_ready;
  logic [BUS_WIDTH-1:0] y;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] xfer_count;

  modport master (
    output a, b, c, d, in_valid, out_ready,
    input  in_ready, y, out_sel, out_valid, xfer_count
  );

  modport slave (
    input  a, b, c, d, in_valid, out_ready,
    output in_ready, y, out_sel, out_valid, xfer_count
  );

endinterface
`default_nettype wire

// File: rtl/rr_mux_nbit_x4_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_x4
// Brief   : Combinational round-robin grant from request vector and pointer
// Revision: 1.0
// ============================================================================
module rr_arbiter_x4
  import mux_pkg::*;
(
  input  wire logic [NUM_CH-1:0] i_req,
  input  wire logic [SEL_W-1:0]  i_ptr,
  output logic                   o_found,
  output logic [SEL_W-1:0]       o_idx
);

  pick_t w_pick;

  assign w_pick  = rr_pick(i_req, i_ptr);
  assign o_found = w_pick.found;
  assign o_idx   = w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/rr_mux_nbit_x4.sv
`default_nettype none
// ============================================================================
// Module  : rr_mux_nbit_x4
// Brief   : Round-robin 4-to-1 stream merger with registered output and count
// Revision: 1.0
// ============================================================================
module rr_mux_nbit_x4
  import mux_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  rr_mux_nbit_x4_if.slave bus
);

  logic [SEL_W-1:0]     r_ptr;
  logic [BUS_WIDTH-1:0] r_y;
  logic [SEL_W-1:0]     r_sel;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_count;

  logic                 w_load;
  logic                 w_found;
  logic [SEL_W-1:0]     w_idx;
  logic [BUS_WIDTH-1:0] w_data;
  logic [NUM_CH-1:0]    w_ready;

  rr_arbiter_x4 u_arb (
    .i_req   (bus.in_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Output slot is free when empty or being drained this cycle.
  assign w_load = !r_valid || bus.out_ready;

  always_comb begin
    w_ready = '0;
    if (!reset && w_found && w_load) begin
      w_ready[w_idx] = 1'b1;
    end
  end

  always_comb begin
    w_data = bus.a;
    case (w_idx)
      2'd0:    w_data = bus.a;
      2'd1:    w_data = bus.b;
      2'd2:    w_data = bus.c;
      default: w_data = bus.d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_y     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_load) begin
        if (w_found) begin
          r_y     <= w_data;
          r_sel   <= w_idx;
          r_valid <= 1'b1;
          r_ptr   <= w_idx + 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (r_valid && bus.out_ready) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.y          = r_y;
  assign bus.out_sel    = r_sel;
  assign bus.out_valid  = r_valid;
  assign bus.xfer_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_nbit_x4.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_mux_nbit_x4
// Brief   : Vector table, hand sequences and randomized round trip for the merger
// Revision: 1.0
// ============================================================================
module tb_rr_mux_nbit_x4;

  logic clk;
  logic reset;

  rr_mux_nbit_x4_if #(.BUS_WIDTH(8), .CNT_WIDTH(16)) bus ();

  rr_mux_nbit_x4 #(.BUS_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] iv;
    logic       ordy;
    logic [7:0] a, b, c, d;
    logic [3:0] e_rdy;
    logic       e_val;
    logic [7:0] e_y;
    logic [1:0] e_sel;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] word;
  } sb_t;

  int   n_pass;
  int   n_total;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(logic rst, logic [3:0] iv, logic ordy, logic [7:0] a, b, c, d,
                              logic [3:0] e_rdy, logic e_val, logic [7:0] e_y,
                              logic [1:0] e_sel, logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ordy = ordy;
    v.a = a; v.b = b; v.c = c; v.d = d;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_y = e_y; v.e_sel = e_sel; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Drive one cycle: in_ready checked before the edge, registers after it.
  task automatic step(input vec_t v, input string tag);
    reset        = v.rst;
    bus.in_valid = v.iv;
    bus.out_ready = v.ordy;
    bus.a = v.a; bus.b = v.b; bus.c = v.c; bus.d = v.d;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.e_val));
    chk({tag, ".y"}, 32'(bus.y), 32'(v.e_y));
    chk({tag, ".out_sel"}, 32'(bus.out_sel), 32'(v.e_sel));
    chk({tag, ".xfer_count"}, 32'(bus.xfer_count), 32'(v.e_cnt));
  endtask

  // Reference state for the randomized phase
  logic       m_valid;
  logic [7:0] m_y;
  logic [1:0] m_sel;
  int         m_ptr;
  int         m_cnt;
  sb_t        sb[$];
  logic [7:0] dmx[4];
  logic [7:0] ch[4];
  logic [3:0] iv;
  int         n_words;

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.in_valid = '0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    #1;

    tbl[0]  = mk(1, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0000, 0, 8'h00, 2'd0, 16'd0);
    tbl[1]  = mk(1, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0000, 0, 8'h00, 2'd0, 16'd0);
    tbl[2]  = mk(0, 4'b0100, 1, 8'h01, 8'h02, 8'hA5, 8'h04, 4'b0100, 1, 8'hA5, 2'd2, 16'd0);
    tbl[3]  = mk(0, 4'b0000, 1, 8'h01, 8'h02, 8'h33, 8'h04, 4'b0000, 0, 8'hA5, 2'd2, 16'd1);
    tbl[4]  = mk(1, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0000, 0, 8'h00, 2'd0, 16'd0);
    tbl[5]  = mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0001, 1, 8'd10, 2'd0, 16'd0);
    tbl[6]  = mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0010, 1, 8'd11, 2'd1, 16'd1);
    tbl[7]  = mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0100, 1, 8'd12, 2'd2, 16'd2);
    tbl[8]  = mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b1000, 1, 8'd13, 2'd3, 16'd3);
    tbl[9]  = mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0001, 1, 8'd10, 2'd0, 16'd4);
    tbl[10] = mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0010, 1, 8'd11, 2'd1, 16'd5);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: output frozen for 5 clocks, then one transfer plus next grant.
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 4'hF, 0, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0000, 1, 8'd11, 2'd1, 16'd5),
           $sformatf("hold%0d", i));
    end
    step(mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0100, 1, 8'd12, 2'd2, 16'd6), "release");

    // Reset while a word is stalled discards it and rewinds the pointer.
    step(mk(0, 4'hF, 0, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0000, 1, 8'd12, 2'd2, 16'd6), "stall");
    step(mk(1, 4'hF, 0, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0000, 0, 8'd0, 2'd0, 16'd0), "rst_mid");
    step(mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0001, 1, 8'd10, 2'd0, 16'd0), "post_rst0");
    step(mk(0, 4'hF, 1, 8'd10, 8'd11, 8'd12, 8'd13, 4'b0010, 1, 8'd11, 2'd1, 16'd1), "post_rst1");

    // Randomized round trip against a behavioural model and a demux model.
    reset = 1'b1;
    bus.in_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_valid = 0; m_y = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; n_words = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      dmx[i] = '0;
      ch[i]  = 8'($urandom);
    end
    iv = 4'($urandom);

    for (int cyc = 0; cyc < 300; cyc++) begin
      logic       ordy, load, found, hs;
      int         g;
      logic [3:0] e_rdy;
      sb_t        e;

      ordy = ($urandom_range(0, 3) != 0);
      bus.in_valid = iv;
      bus.out_ready = ordy;
      bus.a = ch[0]; bus.b = ch[1]; bus.c = ch[2]; bus.d = ch[3];

      load = !m_valid || ordy;
      found = 0;
      g = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && iv[(m_ptr + k) % 4]) begin
          found = 1;
          g = (m_ptr + k) % 4;
        end
      end
      e_rdy = (found && load) ? 4'(1 << g) : 4'b0000;
      hs = m_valid && ordy;

      #1;
      chk("rnd.in_ready", 32'(bus.in_ready), 32'(e_rdy));
      if (bus.out_valid && bus.out_ready) dmx[bus.out_sel] = bus.y;
      if (hs) begin
        if (sb.size() == 0) begin
          chk("rnd.sb_empty", 32'(0), 32'(1));
        end else begin
          e = sb.pop_front();
          chk("rnd.roundtrip", 32'(dmx[e.idx]), 32'(e.word));
          n_words++;
        end
      end

      if (load) begin
        if (found) begin
          m_valid = 1;
          m_y = ch[g];
          m_sel = 2'(g);
          m_ptr = (g + 1) % 4;
          e.idx = 2'(g);
          e.word = ch[g];
          sb.push_back(e);
        end else begin
          m_valid = 0;
        end
      end
      if (hs) m_cnt = (m_cnt + 1) % 65536;

      @(posedge clk);
      #1;
      chk("rnd.out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd.y", 32'(bus.y), 32'(m_y));
        chk("rnd.out_sel", 32'(bus.out_sel), 32'(m_sel));
      end
      chk("rnd.xfer_count", 32'(bus.xfer_count), 32'(m_cnt));

      // A pending channel holds its word; others may change freely.
      for (int i = 0; i < 4; i++) begin
        if (!(iv[i] && !(e_rdy[i]))) begin
          iv[i] = ($urandom_range(0, 1) == 1);
          ch[i] = 8'($urandom);
        end
      end
    end

    chk("rnd.min_words", 32'(n_words >= 8), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
